arith_seq_unit: RTL and testbench
=================================

Name: arith_seq_unit

Overview:
Multicycle arithmetic responder for the RSA pipeline's execute stage. It accepts one ARITH_ADD, ARITH_SUB or ARITH_MOD request from the pipeline through a start/busy/done handshake and returns a registered result. ADD and SUB complete in one cycle. MOD is computed by a restoring shift-subtract remainder over WIDTH cycles. The pipeline stalls on busy_o.

Parameters:
WIDTH, 32, operand and result width in bits (≥2)
CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous, active-low reset
start_i  input  1  request strobe; sampled only in IDLE
op_i  input  3  operation: ARITH_ADD=3'b000, ARITH_SUB=3'b001, ARITH_MOD=3'b101
a_i  input  WIDTH  operand A (dividend for MOD)
b_i  input  WIDTH  operand B (modulus for MOD)
busy_o  output  1  high whenever the state is not IDLE
done_o  output  1  one-cycle pulse; result_o and the flags are valid in this cycle
result_o  output  WIDTH  result, held until the next done_o
div_zero_o  output  1  MOD with b=0; valid with done_o, held
illegal_o  output  1  op_i not ADD/SUB/MOD; valid with done_o, held

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - result_o, div_zero_o, illegal_o, done_o, busy_o and all internal registers go to 0.
- Reset mid-operation aborts the operation with no done_o. The first start_i is accepted in the first cycle after rst_n deasserts.
- States:
  - IDLE: start_i=1 captures op_i, a_i and b_i into registers at this edge.
    - ADD/SUB/illegal op, or MOD with b_i=0 → DONE.
    - MOD with b_i≠0 → CALC, counter=WIDTH, rem=0, shift register=a_i.
  - CALC, each cycle:
    - rem' = {rem[WIDTH-1:0], sh[WIDTH-1]}, with rem WIDTH+1 bits wide.
    - sh <<= 1.
    - If rem' ≥ {1'b0,b}, then rem = rem' − b; otherwise rem = rem'.
    - counter decrements; when counter reaches 1 at the edge, go to DONE.
  - DONE: done_o=1 for exactly one cycle, then unconditionally → IDLE.
- Start acceptance:
  - start_i is ignored in CALC and DONE; there is no queuing.
  - The pipeline holds start_i until busy_o=0.
- Latency (start_i accepted at edge T):
  - ADD/SUB/illegal/div-by-zero: done_o during cycle T+1.
  - MOD: CALC occupies cycles T+1..T+WIDTH; done_o during cycle T+WIDTH+1.
  - MOD latency is fixed and data-independent: no early exit when a<b or a=0.
  - Minimum issue interval is 2 cycles (DONE → IDLE → accept).
- Arithmetic:
  - ADD: (a+b) mod 2^WIDTH; carry discarded.
  - SUB: (a−b) mod 2^WIDTH, two's complement.
  - MOD: unsigned a mod b, result in [0, b−1].
- Result registers are written on the edge entering DONE:
  - result_o = computed value.
  - div_zero_o = 1 only for MOD with b=0; result_o = a in that case.
  - illegal_o = 1 only for an unsupported op; result_o = 0 in that case.
  - All flags not applicable to the completed operation are cleared.
- Held operands: a_i and b_i may change after acceptance; they are not re-sampled.

Test Plan:
- Reset then ADD, a=0xFFFF_FFFF, b=0x2 → done_o at T+1, result_o=0x1, div_zero_o=0, illegal_o=0; busy_o=1 only in the done cycle.
- SUB, a=5, b=7 → done_o at T+1, result_o=0xFFFF_FFFE.
- MOD, a=100, b=7 → busy_o high for T+1..T+33; done_o only at T+33; result_o=2. Repeat with a=0xFFFF_FFFF, b=0x10001 → result_o=0. Repeat with a=3, b=10 → result_o=3, same 33-cycle latency.
- MOD, a=55, b=0 → done_o at T+1, result_o=55, div_zero_o=1. A following ADD 1+1 → result_o=2, div_zero_o=0.
- Hold start_i=1 with changing op/operands during a MOD → no extra done_o; the MOD result is unchanged. An op of 3'b010 issued after IDLE → done_o at T+1, result_o=0, illegal_o=1.
- Assert rst_n=0 at T+10 of a MOD → outputs 0 immediately (asynchronous), no done_o. A new ADD 3+4 after release → result_o=7 at T'+1.

Source files
------------

// File: rtl/arith_seq_unit.sv
// Multicycle arithmetic responder: single-cycle ADD/SUB, restoring shift-subtract MOD.
// Start/busy/done handshake; results and flags are held until the next completion.
module arith_seq_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             div_zero_o,
  output logic             illegal_o
);

  // state | meaning
  // IDLE  | waiting for start_i
  // CALC  | one remainder step per cycle, WIDTH cycles
  // DONE  | done_o pulse, result registers valid

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [2:0] ARITH_ADD = 3'b000;
  localparam logic [2:0] ARITH_SUB = 3'b001;
  localparam logic [2:0] ARITH_MOD = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic             r_div_zero;
  logic             r_illegal;

  logic [WIDTH:0]   w_rem_sh;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_imm_result;
  logic             w_imm_div_zero;
  logic             w_imm_illegal;
  logic             w_accept;
  logic             w_last;

  assign w_accept = (r_state == IDLE) && start_i;
  assign w_last   = (r_cnt == CNT_W'(1));

  // Remainder always stays below b, so the WIDTH-bit difference is exact.
  assign w_rem_sh  = {r_rem, r_sh[WIDTH-1]};
  assign w_ge      = (w_rem_sh >= {1'b0, r_b});
  assign w_rem_nxt = w_ge ? (w_rem_sh[WIDTH-1:0] - r_b) : w_rem_sh[WIDTH-1:0];

  always_comb begin
    w_imm_result   = '0;
    w_imm_div_zero = 1'b0;
    w_imm_illegal  = 1'b0;
    case (op_i)
      ARITH_ADD: w_imm_result = a_i + b_i;
      ARITH_SUB: w_imm_result = a_i - b_i;
      ARITH_MOD: begin
        // Only reaches DONE directly when b_i is zero.
        w_imm_result   = a_i;
        w_imm_div_zero = 1'b1;
      end
      default:   w_imm_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start_i) begin
          if ((op_i == ARITH_MOD) && (b_i != '0)) w_state_nxt = CALC;
          else                                    w_state_nxt = DONE;
        end
      end
      CALC:    if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_rem      <= '0;
      r_sh       <= '0;
      r_b        <= '0;
      r_result   <= '0;
      r_div_zero <= 1'b0;
      r_illegal  <= 1'b0;
    end else if (w_accept) begin
      r_b <= b_i;
      if (w_state_nxt == CALC) begin
        r_cnt <= CNT_W'(WIDTH);
        r_rem <= '0;
        r_sh  <= a_i;
      end else begin
        r_result   <= w_imm_result;
        r_div_zero <= w_imm_div_zero;
        r_illegal  <= w_imm_illegal;
      end
    end else if (r_state == CALC) begin
      r_rem <= w_rem_nxt;
      r_sh  <= {r_sh[WIDTH-2:0], 1'b0};
      r_cnt <= r_cnt - CNT_W'(1);
      if (w_last) begin
        r_result   <= w_rem_nxt;
        r_div_zero <= 1'b0;
        r_illegal  <= 1'b0;
      end
    end
  end

  assign busy_o     = (r_state != IDLE);
  assign done_o     = (r_state == DONE);
  assign result_o   = r_result;
  assign div_zero_o = r_div_zero;
  assign illegal_o  = r_illegal;

endmodule

// File: tb/tb_arith_seq_unit.sv
// Directed bench for arith_seq_unit: vector table of single operations plus
// hand-written sequences for held start, back-to-back issue and reset abort.
module tb_arith_seq_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_i = 1'b0;
  logic [2:0]   op_i = 3'b000;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         busy_o, done_o, div_zero_o, illegal_o;
  logic [W-1:0] result_o;

  int n_pass = 0;
  int n_total = 0;

  arith_seq_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .op_i(op_i),
    .a_i(a_i), .b_i(b_i), .busy_o(busy_o), .done_o(done_o),
    .result_o(result_o), .div_zero_o(div_zero_o), .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         dz;
    logic         ill;
    int           lat;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic wait_idle();
    int guard = 0;
    @(negedge clk);
    while (busy_o && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (busy_o) chk("idle_timeout", 64'(busy_o), 64'd0);
  endtask

  // Issue one request and follow it to done_o; checks latency, busy, result, flags.
  task automatic run_op(input vec_t v);
    int lat;
    int busy_gap;
    wait_idle();
    start_i = 1'b1; op_i = v.op; a_i = v.a; b_i = v.b;
    @(posedge clk); #1;
    start_i = 1'b0; a_i = ~v.a; b_i = ~v.b; op_i = 3'b110;
    lat = 1;
    busy_gap = 0;
    while (!done_o && lat < 100) begin
      if (!busy_o) busy_gap++;
      @(posedge clk); #1;
      lat++;
    end
    chk({v.name, "_lat"}, 64'(lat), 64'(v.lat));
    chk({v.name, "_busy"}, 64'({busy_gap == 0, busy_o}), 64'b11);
    chk({v.name, "_res"}, 64'(result_o), 64'(v.res));
    chk({v.name, "_flags"}, 64'({div_zero_o, illegal_o}), 64'({v.dz, v.ill}));
    @(posedge clk); #1;
    chk({v.name, "_pulse"}, 64'({done_o, busy_o}), 64'b00);
  endtask

  initial begin
    int dones;
    int cyc;
    vecs[0]  = '{"add_wrap",  3'b000, 32'hFFFF_FFFF, 32'h2,         32'h1,         1'b0, 1'b0, 1};
    vecs[1]  = '{"sub_neg",   3'b001, 32'd5,         32'd7,         32'hFFFF_FFFE, 1'b0, 1'b0, 1};
    vecs[2]  = '{"mod_100_7", 3'b101, 32'd100,       32'd7,         32'd2,         1'b0, 1'b0, 33};
    vecs[3]  = '{"mod_exact", 3'b101, 32'hFFFF_FFFF, 32'h10001,     32'h0,         1'b0, 1'b0, 33};
    vecs[4]  = '{"mod_a_lt_b",3'b101, 32'd3,         32'd10,        32'd3,         1'b0, 1'b0, 33};
    vecs[5]  = '{"mod_dz",    3'b101, 32'd55,        32'd0,         32'd55,        1'b1, 1'b0, 1};
    vecs[6]  = '{"add_1_1",   3'b000, 32'd1,         32'd1,         32'd2,         1'b0, 1'b0, 1};
    vecs[7]  = '{"illegal2",  3'b010, 32'd9,         32'd4,         32'd0,         1'b0, 1'b1, 1};
    vecs[8]  = '{"sub_0_1",   3'b001, 32'd0,         32'd1,         32'hFFFF_FFFF, 1'b0, 1'b0, 1};
    vecs[9]  = '{"mod_b1",    3'b101, 32'd1000,      32'd1,         32'd0,         1'b0, 1'b0, 33};
    vecs[10] = '{"mod_bmax",  3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1,         1'b0, 1'b0, 33};
    vecs[11] = '{"mod_pow2_3",3'b101, 32'h8000_0000, 32'd3,         32'd2,         1'b0, 1'b0, 33};
    vecs[12] = '{"mod_a0",    3'b101, 32'd0,         32'd13,        32'd0,         1'b0, 1'b0, 33};
    vecs[13] = '{"illegal7",  3'b111, 32'd1,         32'd1,         32'd0,         1'b0, 1'b1, 1};

    #12;
    chk("rst_outputs", 64'({busy_o, done_o, div_zero_o, illegal_o}), 64'd0);
    chk("rst_result", 64'(result_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_op(vecs[i]);

    // Held start with changing inputs during MOD: exactly one done, MOD result intact.
    wait_idle();
    start_i = 1'b1; op_i = 3'b101; a_i = 32'd100; b_i = 32'd7;
    @(posedge clk); #1;
    dones = 0;
    cyc = 1;
    while (!done_o && cyc < 100) begin
      op_i = 3'(cyc % 3); a_i = 32'(cyc * 77); b_i = 32'(cyc);
      @(posedge clk); #1;
      cyc++;
    end
    if (done_o) dones++;
    start_i = 1'b0;
    chk("hold_lat", 64'(cyc), 64'd33);
    chk("hold_res", 64'(result_o), 64'd2);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (done_o) dones++;
    end
    chk("hold_dones", 64'(dones), 64'd1);

    // Back-to-back issue at minimum interval.
    wait_idle();
    start_i = 1'b1; op_i = 3'b000; a_i = 32'd10; b_i = 32'd20;
    @(posedge clk); #1;
    op_i = 3'b001; a_i = 32'd50; b_i = 32'd8;
    @(posedge clk); #1;
    chk("b2b_first", 64'({done_o, result_o}), {31'd0, 1'b0, 32'd30});
    @(posedge clk); #1;
    start_i = 1'b0;
    chk("b2b_second", 64'({done_o, result_o}), {31'd0, 1'b1, 32'd42});

    // Asynchronous reset in the middle of a MOD aborts it silently.
    wait_idle();
    start_i = 1'b1; op_i = 3'b101; a_i = 32'd1234; b_i = 32'd100;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", 64'({busy_o, done_o, div_zero_o, illegal_o}), 64'd0);
    chk("abort_result", 64'(result_o), 64'd0);
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done_o || busy_o) dones++;
    end
    chk("abort_quiet", 64'(dones), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op('{"post_rst_add", 3'b000, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 1});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
